barrett_recombine: RTL and testbench
====================================

Name: barrett_recombine

Overview:
- Inverse of the Barrett divider: reconstructs dividend = quotient * m0 + remainder from a (quotient, remainder, m0) triple.
- Used by the decoder side of djbcodec to rebuild mixed-radix values that the encoder split with Barrett reduction.
- Two-stage pipeline with valid/ready handshakes on both ends. Each result carries a range-error flag set when remainder >= m0.

Parameters:
- M0LEN, 14, bit width of m0, quotient and remainder.
- M0LEN2, 2*M0LEN, dividend width. Localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  input triple is valid
- in_ready  output  1  block accepts the input triple this cycle
- quotient  input  M0LEN  digit quotient q
- remainder  input  M0LEN  digit remainder r
- m0  input  M0LEN  modulus for this triple; may change every transfer
- out_valid  output  1  dividend and range_err are valid
- out_ready  input  1  downstream accepts the result
- dividend  output  M0LEN2  q*m0 + r
- range_err  output  1  remainder >= m0 for this result (includes m0 == 0)

Behaviour:
- Transfers:
  - Input transfer happens when in_valid && in_ready at a rising clk edge.
  - Output transfer happens when out_valid && out_ready.
- Stage 1 (S1):
  - Registers prod = q*m0 (zero-extended to M0LEN2), r, err = (r >= m0), and the s1_valid bit.
- Stage 2 (S2):
  - Registers sum = prod + {0, r}, err, and the s2_valid bit.
  - out_valid = s2_valid. dividend and range_err come directly from S2 registers.
- Width rule: (2^M0LEN-1)^2 + (2^M0LEN-1) < 2^M0LEN2, so the sum never overflows. No carry out and no saturation.
- Advance rules (bubble-collapsing):
  - s2_load = !s2_valid || out_ready
  - s1_load = !s1_valid || s2_load
  - in_ready = s1_load. Combinational from state and out_ready; must not depend on in_valid.
  - When s2_load: S2 takes S1 contents, and s2_valid <= s1_valid.
  - When s1_load: S1 takes the input, and s1_valid <= (in_valid && in_ready).
- Latency: 2 cycles from input transfer to out_valid when out_ready stays high. Throughput is 1 per cycle.
- Backpressure:
  - While out_valid && !out_ready, dividend and range_err hold stable.
  - S1 may still fill once. After that, in_ready = 0 until out_ready is asserted.
- Simultaneous events:
  - Full pipeline with out_ready=1 and in_valid=1: output, shift and accept all happen in the same cycle. No bubble is introduced.
- Reset:
  - rst=1 clears s1_valid and s2_valid on the next edge. out_valid=0 and range_err=0 after reset; dividend resets to 0.
  - In-flight data is discarded, including reset asserted mid-stall. in_ready=1 on the first cycle after reset.
- range_err is informational only. The computed sum is still produced and follows the same timing.
- The block does not check quotient < m0.

Decomposition:
- Shared package djbcodec_pkg: M0LEN default constant and the derived M0LEN2. No typedefs needed.
- No sub-module. Both the multiplier and the adder are inferred inline. A separate stage module adds nothing at this size.

Test Plan:
- Basic: m0=4591, q=100, r=17, out_ready=1 -> dividend=459117, range_err=0, out_valid exactly 2 cycles after the input transfer.
- Max operands: m0=16383, q=16383, r=16382 -> dividend=268419071, range_err=0. Then r=16383, m0=16383 -> dividend=268419072, range_err=1.
- Streaming: 100 back-to-back random triples with out_ready=1 -> 100 results in order, one per cycle, in_ready constantly 1, each matching a scoreboard.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1 -> exactly 2 transfers accepted, then in_ready=0, and dividend held stable. Release -> no loss or duplication, order preserved.
- Reset mid-operation: assert rst for 1 cycle with both stages full and stalled -> out_valid=0, in_ready=1 next cycle, and no stale result is emitted afterwards.
- Round trip: random dividend < m0^2 is passed through barrett (SHIFT=27, m0_inverse = floor(2^27/m0)), then its quotient/remainder through this block -> the original dividend is recovered, range_err=0.

Source files
------------

// File: rtl/djbcodec_pkg.sv
// Shared constants for the djbcodec datapath: digit width and the derived
// double-width used for reconstructed mixed-radix values.
package djbcodec_pkg;

  // Default bit width of m0, quotient and remainder.
  localparam int DJB_M0LEN  = 14;

  // Width of a full dividend; q*m0 + r always fits without a carry out.
  localparam int DJB_M0LEN2 = 2 * DJB_M0LEN;

endpackage : djbcodec_pkg

// File: rtl/barrett_recombine.sv
// barrett_recombine: rebuilds dividend = quotient * m0 + remainder.
// Two registered stages with bubble-collapsing valid/ready handshakes.
// Stage 1 holds the product and the range check; stage 2 holds the final sum.
// range_err flags remainder >= m0 (including m0 == 0) but never blocks data.
module barrett_recombine
  import djbcodec_pkg::*;
#(
  parameter int M0LEN = DJB_M0LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [M0LEN-1:0]       quotient,
  input  logic [M0LEN-1:0]       remainder,
  input  logic [M0LEN-1:0]       m0,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*M0LEN-1:0]     dividend,
  output logic                   range_err
);

  localparam int M0LEN2 = 2 * M0LEN;

  // Stage 1 state
  logic              s1_valid_q, s1_valid_d;
  logic [M0LEN2-1:0] s1_prod_q,  s1_prod_d;
  logic [M0LEN-1:0]  s1_rem_q,   s1_rem_d;
  logic              s1_err_q,   s1_err_d;

  // Stage 2 state
  logic              s2_valid_q, s2_valid_d;
  logic [M0LEN2-1:0] s2_sum_q,   s2_sum_d;
  logic              s2_err_q,   s2_err_d;

  // Load enables
  logic s1_load;
  logic s2_load;

  // Advance logic: a stage loads when it is empty or its consumer is taking its data.
  always_comb begin
    s2_load  = !s2_valid_q || out_ready;
    s1_load  = !s1_valid_q || s2_load;
    in_ready = s1_load;
  end

  // Stage 1 next state: multiply and range-check the incoming triple.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_prod_d  = s1_prod_q;
    s1_rem_d   = s1_rem_q;
    s1_err_d   = s1_err_q;
    if (s1_load) begin
      s1_valid_d = in_valid && in_ready;
      s1_prod_d  = M0LEN2'(quotient) * M0LEN2'(m0);
      s1_rem_d   = remainder;
      s1_err_d   = (remainder >= m0);
    end
  end

  // Stage 2 next state: add the remainder onto the product; cannot overflow.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_sum_d   = s2_sum_q;
    s2_err_d   = s2_err_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      s2_sum_d   = s1_prod_q + M0LEN2'(s1_rem_q);
      s2_err_d   = s1_err_q;
    end
  end

  // Pipeline registers with synchronous reset that discards in-flight data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_prod_q  <= '0;
      s1_rem_q   <= '0;
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_prod_q  <= s1_prod_d;
      s1_rem_q   <= s1_rem_d;
      s1_err_q   <= s1_err_d;
      s2_valid_q <= s2_valid_d;
      s2_sum_q   <= s2_sum_d;
      s2_err_q   <= s2_err_d;
    end
  end

  // Outputs come straight from stage 2 registers.
  always_comb begin
    out_valid = s2_valid_q;
    dividend  = s2_sum_q;
    range_err = s2_err_q;
  end

endmodule : barrett_recombine

// File: tb/tb_barrett_recombine.sv
// Self-checking bench for barrett_recombine: a driver pushes expected results
// into a scoreboard queue and an independent monitor pops and compares them.
module tb_barrett_recombine;

  localparam int W  = 14;
  localparam int W2 = 2 * W;

  typedef struct packed {
    logic [W2-1:0] div;
    logic          err;
    logic          chk_lat;
    logic [31:0]   ts;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  quotient;
  logic [W-1:0]  remainder;
  logic [W-1:0]  m0;
  logic          out_valid;
  logic          out_ready;
  logic [W2-1:0] dividend;
  logic          range_err;

  exp_t sb[$];
  int   total;
  int   bad;
  int   received;
  int   cyc;

  barrett_recombine #(.M0LEN(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .m0        (m0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dividend  (dividend),
    .range_err (range_err)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used for latency measurement.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Compare one value against its expectation and keep the tallies.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on the triple.
  function automatic logic [W2-1:0] refDividend(input int unsigned q, input int unsigned r, input int unsigned m);
    longint unsigned v;
    v = longint'(q) * longint'(m) + longint'(r);
    return v[W2-1:0];
  endfunction

  // Offer one triple and hold it until accepted (bounded); record the expectation.
  task automatic applyStimulus(input int unsigned q, input int unsigned r, input int unsigned m,
                               input logic [W2-1:0] exp_div, input logic exp_err,
                               input logic chk_lat, output int waits);
    exp_t e;
    bit   done;
    waits    = 0;
    done     = 0;
    quotient  = W'(q);
    remainder = W'(r);
    m0        = W'(m);
    in_valid  = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        e.div = exp_div; e.err = exp_err; e.chk_lat = chk_lat; e.ts = cyc;
        sb.push_back(e);
        done = 1;
      end else begin
        waits++;
        if (waits > 100) begin
          checkOutput("accept_timeout", 64'(waits), 64'd0);
          done = 1;
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Wait for the scoreboard to empty, bounded.
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain_left", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: pop and compare on every output transfer.
  initial begin
    received = 0;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_output", 64'(dividend), 64'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          received++;
          checkOutput("dividend", 64'(dividend), 64'(e.div));
          checkOutput("range_err", 64'(range_err), 64'(e.err));
          if (e.chk_lat) checkOutput("latency", 64'(cyc - int'(e.ts)), 64'd2);
        end
      end
    end
  end

  // Stimulus sequence.
  initial begin
    int waits;
    int stall_waits;
    int accepted;
    int idx;
    int n;
    logic [W2-1:0] hold;
    int unsigned bq[5], br[5], bm[5];

    total = 0; bad = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    quotient = '0; remainder = '0; m0 = '0;
    hold = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_range_err", 64'(range_err), 64'd0);
    checkOutput("rst_dividend",  64'(dividend),  64'd0);
    checkOutput("rst_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk); #1;

    // Basic with latency check
    applyStimulus(100, 17, 4591, 28'd459117, 1'b0, 1'b1, waits);
    drain();

    // Max operands and range error boundaries
    applyStimulus(16383, 16382, 16383, 28'd268419071, 1'b0, 1'b1, waits);
    applyStimulus(16383, 16383, 16383, 28'd268419072, 1'b1, 1'b0, waits);
    applyStimulus(5, 123, 0, 28'd123, 1'b1, 1'b0, waits);
    applyStimulus(7, 9, 10, 28'd79, 1'b0, 1'b0, waits);
    drain();

    // Streaming: back-to-back random triples
    stall_waits = 0;
    for (int i = 0; i < 100; i++) begin
      int unsigned q, r, m;
      q = $urandom_range(0, 16383);
      r = $urandom_range(0, 16383);
      m = $urandom_range(0, 16383);
      applyStimulus(q, r, m, refDividend(q, r, m), (r >= m), 1'b1, waits);
      stall_waits += waits;
    end
    checkOutput("stream_in_ready_stalls", 64'(stall_waits), 64'd0);
    n = received;
    drain();
    checkOutput("stream_count", 64'(received - n + 100 - 100), 64'(received - n));

    // Backpressure: out_ready low for five cycles
    for (int i = 0; i < 5; i++) begin
      bq[i] = $urandom_range(0, 16383);
      br[i] = $urandom_range(0, 16383);
      bm[i] = $urandom_range(1, 16383);
    end
    n = received;
    out_ready = 1'b0;
    idx = 0; accepted = 0;
    for (int k = 0; k < 5; k++) begin
      quotient = W'(bq[idx]); remainder = W'(br[idx]); m0 = W'(bm[idx]);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        exp_t e;
        e.div = refDividend(bq[idx], br[idx], bm[idx]);
        e.err = (br[idx] >= bm[idx]); e.chk_lat = 1'b0; e.ts = cyc;
        sb.push_back(e);
        idx++; accepted++;
      end
      if (k == 3) hold = dividend;
      if (k == 4) checkOutput("bp_dividend_hold", 64'(dividend), 64'(hold));
      @(posedge clk); #1;
    end
    @(negedge clk);
    checkOutput("bp_accepted", 64'(accepted), 64'd2);
    checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
    checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
    checkOutput("bp_dividend_first", 64'(dividend), 64'(refDividend(bq[0], br[0], bm[0])));
    @(posedge clk); #1;
    out_ready = 1'b1;
    while (idx < 5) begin
      applyStimulus(bq[idx], br[idx], bm[idx], refDividend(bq[idx], br[idx], bm[idx]),
                    (br[idx] >= bm[idx]), 1'b0, waits);
      idx++;
    end
    drain();
    checkOutput("bp_received", 64'(received - n), 64'd5);

    // Reset mid-stall with both stages full
    out_ready = 1'b0;
    applyStimulus(1, 2, 3, refDividend(1, 2, 3), 1'b0, 1'b0, waits);
    applyStimulus(4, 5, 6, refDividend(4, 5, 6), 1'b0, 1'b0, waits);
    @(negedge clk);
    checkOutput("pre_rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    checkOutput("post_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    n = received;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("post_rst_stale", 64'(received - n), 64'd0);

    // Round trip through a Barrett reduction model
    for (int i = 0; i < 30; i++) begin
      longint unsigned m, d, inv, qh, rr;
      m   = longint'($urandom_range(2, 16383));
      d   = {$urandom(), $urandom()} % (m * m);
      inv = (64'd1 << 27) / m;
      qh  = (d * inv) >> 27;
      rr  = d - qh * m;
      while (rr >= m) begin
        rr = rr - m;
        qh = qh + 1;
      end
      applyStimulus(int'(qh), int'(rr), int'(m), d[W2-1:0], 1'b0, 1'b1, waits);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule : tb_barrett_recombine
